rf_write_sched: RTL
===================

Name: rf_write_sched

Overview:
- Write-port scheduler and scoreboard in front of the 15-entry register file (r0–r14; r15 is the external PC).
- Arbitrates three writeback requesters onto two physical register-file write ports and routes address-15 writes to the PC path.
- Tracks outstanding destination reservations per register so decode can stall on RAW hazards.
- Sits between the writeback/memory stages and the register file, with a query interface to decode.

Parameters:
- DW, 32, data width.
- CNT_W, 2, width of the per-register outstanding-reservation counter; counter saturates at 2^CNT_W-1.
- STARVE_MAX, 4, number of consecutive cycles req2 may be valid and not granted before it is promoted to top priority for port slots.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  3  per-requester write valid; req0 = oldest in program order, req2 = youngest.
- req_addr  in  12  three 4-bit destination addresses, req i at bits [4i+3:4i].
- req_data  in  3*DW  three write data words, req i at bits [DW*i+DW-1:DW*i].
- req_ready  out  3  per-requester grant (combinational).
- rsv_valid  in  1  decode reserves a destination register.
- rsv_addr  in  4  register being reserved.
- rsv_ready  out  1  0 when rsv_addr's counter is saturated.
- qa  in  16  four 4-bit read addresses from decode.
- q_busy  out  4  1 when the matching read address has a nonzero counter; address 15 always reads 0.
- we_a, we_b  out  1 each  physical write-port enables.
- wa_a, wa_b  out  4 each  physical write-port addresses.
- wd_a, wd_b  out  DW each  physical write-port data.
- pc_we  out  1  PC write strobe.
- pc_wd  out  DW  PC write data.

Behaviour:
- Reset: all outputs 0; all counters 0; starvation counter 0. Reset is asynchronous and takes effect mid-transfer: pending registered writes are dropped.
- Handshake: a request transfers in the cycle where req_valid[i] & req_ready[i]. A requester holds valid, addr and data stable until granted.
- Address 15:
  - The first valid address-15 request in req0..req2 order is granted to the PC path.
  - Further address-15 requests in the same cycle are not granted.
  - PC-path grants do not consume a port slot.
- Same-address ordering: a request is not granted if a lower-index requester is valid to the same address and is not granted. Equal addresses always commit oldest-first, one per cycle.
- Port slots:
  - Up to 2 regfile grants per cycle.
  - Default priority is req0 > req1 > req2.
  - When the starvation counter reaches STARVE_MAX, req2 takes the first slot. The ordering rule still applies.
  - Slot A receives the highest-priority grant, slot B the second.
- Starvation counter: increments when req2 is valid and not granted; clears when req2 is granted or not valid; saturates at STARVE_MAX.
- Latency: a grant in cycle N drives we/wa/wd (or pc_we/pc_wd) registered in cycle N+1. Outputs are 1-cycle pulses.
- Scoreboard, one counter per r0..r14:
  - rsv_valid & rsv_ready increments the counter at the clock edge.
  - A registered write that is visible on port A/B decrements its counter at the end of that cycle.
  - Simultaneous increment and decrement on the same register: counter unchanged.
  - Decrement at 0: counter stays 0 (writes without a reservation are legal).
  - Both ports never carry the same address, so at most one decrement per register per cycle.
- rsv to address 15 is ignored; rsv_ready = 1 for it.

Optional Feature:
- Macro: RF_WSCHED_BYPASS_EN.
- When defined, adds outputs fwd_hit (4) and fwd_data (4*DW). For each qa lane, if port A or port B is currently writing that address, fwd_hit = 1 and fwd_data = that port's wd, and q_busy for that lane is forced to 0.
- When not defined, these ports are absent and q_busy is reported unmodified.

Decomposition:
- Shared package holds:
  - REG_PC = 4'd15.
  - NUM_REQ = 3.
  - NUM_WPORT = 2.
  - A wreq_t struct {addr[3:0], data[DW-1:0]}.
- One sub-module: rf_scoreboard, holding the counter array, q_busy and rsv_ready.
- Arbitration and output registers stay in the top.

Test Plan:
- Reset mid-transfer: req0 to r3 granted, then reset asserted before the next edge → we_a stays 0; counter for r3 is 0.
- Three writes: req0 → r1 = 0x11, req1 → r2 = 0x22, req2 → r3 = 0x33 valid together → cycle 1: ready = 3'b011; cycle 2: we_a/wa_a = 1/1, we_b/wa_b = 1/2, ready = 3'b100; cycle 3: wa_a = 3, wd_a = 0x33.
- Same address: req0 and req1 both → r5 = 0xA then 0xB → r5 written 0xA, then 0xB one cycle later; never both on the same cycle.
- Starvation: req0 and req1 continuously valid → req2 granted on the 5th valid cycle (STARVE_MAX = 4).
- Scoreboard: reserve r7 twice, qa lane0 = 7 → q_busy[0] = 1 until the second write to r7 commits; a third reservation gives rsv_ready = 0 only after the counter reaches 3.
- PC: req1 → r15 = 0x100 with req0 → r15 = 0x200 → pc_wd = 0x200 first, then 0x100; regfile ports idle.

Source files
------------

// File: rtl/rf_write_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
package rf_write_sched_pkg;

  localparam int unsigned DW            = 32;
  localparam int unsigned AW            = 4;
  localparam int unsigned WS_CNT_W      = 2;
  localparam int unsigned WS_STARVE_MAX = 4;
  localparam int unsigned NUM_REQ       = 3;
  localparam int unsigned NUM_WPORT     = 2;
  localparam int unsigned NUM_REG       = 15;
  localparam int unsigned NUM_QLANE     = 4;

  localparam logic [AW-1:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wreq_t;

  typedef enum logic {
    PRIO_AGE    = 1'b0,
    PRIO_STARVE = 1'b1
  } prio_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register outstanding-reservation counters for r0..r14 with the decode
// query (q_busy) and reservation back-pressure (rsv_ready).
module rf_scoreboard
  import rf_write_sched_pkg::*;
#(
  parameter int unsigned CNT_W = WS_CNT_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rsv_valid,
  input  logic [AW-1:0]           rsv_addr,
  output logic                    rsv_ready,
  input  logic [NUM_QLANE*AW-1:0] qa,
  output logic [NUM_QLANE-1:0]    q_busy,
  input  logic                    we_a,
  input  logic [AW-1:0]           wa_a,
  input  logic                    we_b,
  input  logic [AW-1:0]           wa_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]   r_cnt [NUM_REG];
  logic [NUM_REG-1:0] w_inc;
  logic [NUM_REG-1:0] w_dec;
  logic [15:0]        w_busy;
  logic [15:0]        w_full;

  // Address 15 is the PC: never busy, never full.
  always_comb begin
    w_busy = '0;
    w_full = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      w_busy[r] = (r_cnt[r] != '0);
      w_full[r] = (r_cnt[r] == CNT_MAX);
    end
  end

  assign rsv_ready = ~w_full[rsv_addr];

  // Port decrements come from the registered writes currently on the ports.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 0; r < NUM_REG; r++) begin
      w_inc[r] = rsv_valid & rsv_ready & (rsv_addr == 4'(r));
      w_dec[r] = (we_a & (wa_a == 4'(r))) | (we_b & (wa_b == 4'(r)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REG; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REG; r++) begin
        if (w_inc[r] & ~w_dec[r]) begin
          r_cnt[r] <= r_cnt[r] + CNT_W'(1);
        end else if (w_dec[r] & ~w_inc[r] & w_busy[r]) begin
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    q_busy = '0;
    for (int l = 0; l < NUM_QLANE; l++) begin
      q_busy[l] = w_busy[qa[AW*l +: AW]];
    end
  end

endmodule

// File: rtl/rf_write_sched.sv
// Write-port scheduler: three writeback requesters onto two regfile ports plus
// the PC path, with RAW scoreboard. Optional forwarding via RF_WSCHED_BYPASS_EN.
module rf_write_sched
  import rf_write_sched_pkg::*;
#(
  parameter int unsigned CNT_W      = WS_CNT_W,
  parameter int unsigned STARVE_MAX = WS_STARVE_MAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*AW-1:0]   req_addr,
  input  logic [NUM_REQ*DW-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    rsv_valid,
  input  logic [AW-1:0]           rsv_addr,
  output logic                    rsv_ready,
  input  logic [NUM_QLANE*AW-1:0] qa,
  output logic [NUM_QLANE-1:0]    q_busy,
  output logic                    we_a,
  output logic                    we_b,
  output logic [AW-1:0]           wa_a,
  output logic [AW-1:0]           wa_b,
  output logic [DW-1:0]           wd_a,
  output logic [DW-1:0]           wd_b,
  output logic                    pc_we,
  output logic [DW-1:0]           pc_wd
`ifdef RF_WSCHED_BYPASS_EN
  ,
  output logic [NUM_QLANE-1:0]    fwd_hit,
  output logic [NUM_QLANE*DW-1:0] fwd_data
`endif
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  wreq_t              w_req [NUM_REQ];
  logic [NUM_REQ-1:0] w_is_pc;
  logic [NUM_REQ-1:0] w_older_same;
  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_pc_gnt;
  logic [NUM_REQ-1:0] w_rf_gnt;
  logic               w_pc_vld;
  logic [1:0]         w_pc_idx;
  prio_e              w_prio;
  logic [1:0]         w_ord [NUM_REQ];
  logic               w_a_vld;
  logic               w_b_vld;
  logic [1:0]         w_a_idx;
  logic [1:0]         w_b_idx;
  logic [NUM_QLANE-1:0] w_sb_busy;

  logic [SW-1:0] r_starve;
  logic          r_we_a;
  logic          r_we_b;
  logic [AW-1:0] r_wa_a;
  logic [AW-1:0] r_wa_b;
  logic [DW-1:0] r_wd_a;
  logic [DW-1:0] r_wd_b;
  logic          r_pc_we;
  logic [DW-1:0] r_pc_wd;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req[i].addr = req_addr[AW*i +: AW];
      w_req[i].data = req_data[DW*i +: DW];
    end
  end

  // A request waits while any older valid requester targets the same address,
  // so equal destinations always commit oldest-first, one per cycle.
  always_comb begin
    w_is_pc      = '0;
    w_older_same = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_is_pc[i] = req_valid[i] & (w_req[i].addr == REG_PC);
      for (int j = 0; j < i; j++) begin
        if (req_valid[j] && (w_req[j].addr == w_req[i].addr)) begin
          w_older_same[i] = 1'b1;
        end
      end
    end
    w_cand = req_valid & ~w_is_pc & ~w_older_same;
  end

  // Only the oldest address-15 request reaches the PC path each cycle.
  always_comb begin
    w_pc_gnt = '0;
    w_pc_vld = 1'b0;
    w_pc_idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_is_pc[i] && !w_pc_vld) begin
        w_pc_vld    = 1'b1;
        w_pc_idx    = 2'(i);
        w_pc_gnt[i] = 1'b1;
      end
    end
  end

  assign w_prio = (r_starve == SW'(STARVE_MAX)) ? PRIO_STARVE : PRIO_AGE;

  always_comb begin
    w_ord[0] = 2'd0;
    w_ord[1] = 2'd1;
    w_ord[2] = 2'd2;
    if (w_prio == PRIO_STARVE) begin
      w_ord[0] = 2'd2;
      w_ord[1] = 2'd0;
      w_ord[2] = 2'd1;
    end
  end

  // Walk candidates in priority order: first winner takes slot A, second slot B.
  always_comb begin
    w_a_vld = 1'b0;
    w_a_idx = 2'd0;
    w_b_vld = 1'b0;
    w_b_idx = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_cand[w_ord[k]]) begin
        if (!w_a_vld) begin
          w_a_vld = 1'b1;
          w_a_idx = w_ord[k];
        end else if (!w_b_vld) begin
          w_b_vld = 1'b1;
          w_b_idx = w_ord[k];
        end
      end
    end
  end

  always_comb begin
    w_rf_gnt = '0;
    if (w_a_vld) w_rf_gnt[w_a_idx] = 1'b1;
    if (w_b_vld) w_rf_gnt[w_b_idx] = 1'b1;
  end

  assign req_ready = w_rf_gnt | w_pc_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
    end else if (req_valid[2] && !req_ready[2]) begin
      if (r_starve != SW'(STARVE_MAX)) begin
        r_starve <= r_starve + SW'(1);
      end
    end else begin
      r_starve <= '0;
    end
  end

  // Grants launch one-cycle write pulses on the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we_a  <= 1'b0;
      r_wa_a  <= '0;
      r_wd_a  <= '0;
      r_we_b  <= 1'b0;
      r_wa_b  <= '0;
      r_wd_b  <= '0;
      r_pc_we <= 1'b0;
      r_pc_wd <= '0;
    end else begin
      r_we_a  <= w_a_vld;
      r_wa_a  <= w_a_vld ? w_req[w_a_idx].addr : '0;
      r_wd_a  <= w_a_vld ? w_req[w_a_idx].data : '0;
      r_we_b  <= w_b_vld;
      r_wa_b  <= w_b_vld ? w_req[w_b_idx].addr : '0;
      r_wd_b  <= w_b_vld ? w_req[w_b_idx].data : '0;
      r_pc_we <= w_pc_vld;
      r_pc_wd <= w_pc_vld ? w_req[w_pc_idx].data : '0;
    end
  end

  assign we_a  = r_we_a;
  assign wa_a  = r_wa_a;
  assign wd_a  = r_wd_a;
  assign we_b  = r_we_b;
  assign wa_b  = r_wa_b;
  assign wd_b  = r_wd_b;
  assign pc_we = r_pc_we;
  assign pc_wd = r_pc_wd;

  rf_scoreboard #(
    .CNT_W (CNT_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .qa        (qa),
    .q_busy    (w_sb_busy),
    .we_a      (r_we_a),
    .wa_a      (r_wa_a),
    .we_b      (r_we_b),
    .wa_b      (r_wa_b)
  );

`ifdef RF_WSCHED_BYPASS_EN
  // A lane whose register is on a port this cycle takes the port data instead of stalling.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    q_busy   = '0;
    for (int l = 0; l < NUM_QLANE; l++) begin
      if (r_we_a && (r_wa_a == qa[AW*l +: AW])) begin
        fwd_hit[l]            = 1'b1;
        fwd_data[DW*l +: DW]  = r_wd_a;
      end else if (r_we_b && (r_wa_b == qa[AW*l +: AW])) begin
        fwd_hit[l]            = 1'b1;
        fwd_data[DW*l +: DW]  = r_wd_b;
      end
      q_busy[l] = w_sb_busy[l] & ~fwd_hit[l];
    end
  end
`else
  assign q_busy = w_sb_busy;
`endif

endmodule
